buffer_fifo_n_bits: RTL
=======================

Name: buffer_fifo_n_bits

Overview:
- Parametrised, clocked successor to the fixed 5-bit pass-through buffer.
- A small synchronous FIFO with valid/ready handshakes on both sides, WIDTH bits wide and DEPTH entries deep.
- Decouples DLX pipeline stages from the sharpening extension, e.g. register-address fields (WIDTH=5) or pixel bytes (WIDTH=8).
- Adds flush, occupancy count and a sticky overflow flag, none of which the pass-through buffer has.

Parameters:
- WIDTH, 5, data bits per entry (>=1).
- DEPTH, 4, number of entries (>=2, need not be a power of two).
- CNT_W, $clog2(DEPTH+1), width of the COUNT output (derived; do not override).

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high reset.
- FLUSH  in  1  synchronous clear of contents and OVF.
- IN_D  in  WIDTH  write data.
- IN_VALID  in  1  write request.
- IN_READY  out  1  FIFO can accept a write this cycle.
- OUT_D  out  WIDTH  head-of-queue data.
- OUT_VALID  out  1  OUT_D holds a valid entry.
- OUT_READY  in  1  consumer accepts the head this cycle.
- COUNT  out  CNT_W  current occupancy, 0..DEPTH.
- OVF  out  1  sticky flag: a write was attempted while full.

Behaviour:
- Clock and reset: one clock (CLK); reset is asynchronous and active-high (RESET).
- While RESET is high: COUNT=0, OUT_VALID=0, IN_READY=1, OVF=0, OUT_D=0, and read/write pointers are 0.
- Storage contents are not reset.
- Handshake definitions:
  - push = IN_VALID & IN_READY.
  - pop = OUT_VALID & OUT_READY.
- Transfers occur on the rising CLK edge.
- Output signal definitions:
  - IN_READY = (COUNT != DEPTH). Purely a function of registered state; no combinational path from OUT_READY.
  - OUT_VALID = (COUNT != 0).
  - OUT_D = mem[rd_ptr] when OUT_VALID, else all zeros. First-word-fall-through: no read-enable latency.
- Latency: data pushed at edge N is visible on OUT_D, with OUT_VALID=1, after edge N when the FIFO was empty. Minimum latency is 1 cycle; there is no same-cycle bypass.
- Pointers:
  - wr_ptr advances on push and rd_ptr advances on pop.
  - Both wrap from DEPTH-1 to 0, including for non-power-of-two DEPTH.
- COUNT update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Full with OUT_READY=1: pop happens, but no push that cycle because IN_READY=0. IN_READY rises on the next cycle.
- Empty with IN_VALID=1: push happens, no pop. OUT_VALID rises next cycle.
- OVF: set on any cycle with IN_VALID=1 & IN_READY=0. Holds until FLUSH or RESET. Data is never overwritten.
- FLUSH=1 at an edge:
  - Pointers and COUNT go to 0 and OVF goes to 0.
  - FLUSH has priority: any push or pop that cycle is discarded.
  - IN_READY is still evaluated from pre-flush state that cycle. A source seeing a handshake during FLUSH must treat the data as dropped.
- RESET asserted mid-operation: outputs go to reset values immediately, with no clock edge needed. Operation resumes on the first edge after deassertion.
- Degenerate use with DEPTH=2 and OUT_READY held high gives a registered 1-cycle delay of IN_D.

Decomposition:
- Shared package contains:
  - dlx_buf_pkg constants: REGADDR_W=5 and PIXEL_W=8.
  - A helper function for the CNT_W computation.
- One natural sub-module: wrap_ptr, a parametrised modulo-DEPTH counter with increment and clear. It is instantiated twice, for the read and write pointers.
- Storage is an inferred register array, not a sub-module.

Test Plan:
- Reset check: assert RESET with clock stopped; also pulse RESET mid-burst → COUNT=0, OUT_VALID=0, IN_READY=1, OVF=0, OUT_D=0 immediately.
- Fill and drain (WIDTH=5, DEPTH=4): push 5'h01,5'h02,5'h03,5'h04 with OUT_READY=0.
  - After the 4th edge: COUNT=4, IN_READY=0, OUT_D=5'h01.
  - Then OUT_READY=1: data comes out in order 01..04 on consecutive cycles, then OUT_VALID=0.
- Overflow: while full, hold IN_VALID=1 with IN_D=5'h1F for 2 cycles → OVF=1, COUNT stays 4, 5'h1F never appears at OUT_D.
  - Then FLUSH → COUNT=0, OVF=0.
- Simultaneous push and pop at COUNT=2 for 10 cycles with an incrementing pattern → COUNT stays 2 and output order is exactly the input order.
- Wrap with non-power-of-two depth (DEPTH=3, WIDTH=8): stream 20 bytes with random OUT_READY → scoreboard matches, and COUNT never exceeds 3.
- Flush priority: at COUNT=2, assert FLUSH together with IN_VALID=1 and OUT_READY=1 → next cycle COUNT=0, OUT_VALID=0, and the flushed data never appears.

Source files
------------

// File: rtl/buffer_fifo_n_bits_pkg.sv
// Shared constants and helpers for the DLX / sharpening-extension buffer FIFO.
// Imported by the FIFO top and its pointer sub-module.
package buffer_fifo_n_bits_pkg;

    localparam int REGADDR_W = 5;
    localparam int PIXEL_W   = 8;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/buffer_fifo_n_bits_wrap_ptr.sv
// Modulo-DEPTH pointer with synchronous clear and increment; DEPTH need not be
// a power of two, so the wrap is an explicit compare rather than overflow.
module wrap_ptr
    import buffer_fifo_n_bits_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/buffer_fifo_n_bits.sv
// First-word-fall-through FIFO with valid/ready on both sides, flush, occupancy
// count and a sticky overflow flag; replaces the fixed 5-bit pass-through buffer.
module buffer_fifo_n_bits
    import buffer_fifo_n_bits_pkg::*;
#(
    parameter int WIDTH = REGADDR_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] IN_D,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT_D,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Ready/valid depend only on registered occupancy: no OUT_READY -> IN_READY path.
    assign IN_READY  = (COUNT != FULL);
    assign OUT_VALID = (COUNT != '0);
    assign OUT_D     = OUT_VALID ? mem[rd_ptr] : '0;

    assign push = IN_VALID & IN_READY;
    assign pop  = OUT_VALID & OUT_READY;

    wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (FLUSH),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (FLUSH),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    // NOTE: the storage array has no reset; OUT_D is masked by OUT_VALID, so stale
    // contents are never observable and the array maps onto plain registers/RAM.
    always_ff @(posedge CLK) begin
        if (push && !FLUSH) begin
            mem[wr_ptr] <= IN_D;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            COUNT <= '0;
        end else if (FLUSH) begin
            COUNT <= '0;
        end else begin
            case ({push, pop})
                2'b10:   COUNT <= COUNT + CNT_W'(1);
                2'b01:   COUNT <= COUNT - CNT_W'(1);
                default: COUNT <= COUNT;
            endcase
        end
    end

    // A refused write sets OVF; the queued data is left intact.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OVF <= 1'b0;
        end else if (FLUSH) begin
            OVF <= 1'b0;
        end else if (IN_VALID && !IN_READY) begin
            OVF <= 1'b1;
        end
    end

endmodule
